// File: rtl/riscvy_muldiv.sv
// riscvy_muldiv: iterative RV M-extension multiply/divide unit for the execute stage.
// One operation at a time: radix-2 shift-add multiply or restoring divide over XLEN
// iterations, then one sign-fix cycle, then a one-cycle done pulse with the rd tag.
// Optional build macro: MULDIV_FAST_MUL_EN -- multiplies complete through a single-cycle
// combinational product; divides keep the iterative path.
module riscvy_muldiv #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  op_a,
  input  logic [XLEN-1:0]  op_b,
  input  logic [TAG_W-1:0] tag_in,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [XLEN-1:0]  result,
  output logic [TAG_W-1:0] tag_out
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_NEG   = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] F_MUL    = 3'd0;
  localparam logic [2:0] F_MULH   = 3'd1;
  localparam logic [2:0] F_MULHSU = 3'd2;
  localparam logic [2:0] F_MULHU  = 3'd3;
  localparam logic [2:0] F_DIV    = 3'd4;
  localparam logic [2:0] F_DIVU   = 3'd5;
  localparam logic [2:0] F_REM    = 3'd6;
  localparam logic [2:0] F_REMU   = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, state_next;

  // Latched operation: op code, result sign, working halves (product or remainder/quotient),
  // unsigned divisor/multiplicand, iteration counter and destination tag.
  logic [2:0]       op_q;
  logic             neg_q;
  logic [XLEN-1:0]  hi_q;
  logic [XLEN-1:0]  lo_q;
  logic [XLEN-1:0]  opb_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TAG_W-1:0] tag_q;

  // Request decode.
  logic             accept;
  logic             a_signed_in;
  logic             b_signed_in;
  logic             a_neg_in;
  logic             b_neg_in;
  logic [XLEN-1:0]  abs_a_in;
  logic [XLEN-1:0]  abs_b_in;
  logic             neg_in;
  logic             div_zero_in;
  logic             overflow_in;
  logic             quick_in;
  logic [XLEN-1:0]  quick_result;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_prod;
`endif

  // Iteration and fix-up datapath.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quot_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_result;

  assign busy   = (state == CALC) || (state == FIX);
  // A flush in the DONE cycle suppresses the pulse so the hazard unit never sees a squashed result.
  assign done   = (state == DONE) && !flush;
  assign accept = start && !busy && !flush;

  // Decode the incoming request: operand magnitudes, result sign and the one-cycle shortcuts.
  always_comb begin
    a_signed_in  = 1'b0;
    b_signed_in  = 1'b0;
    neg_in       = 1'b0;
    quick_result = '0;
    case (funct3)
      F_MULH, F_DIV, F_REM: begin
        a_signed_in = 1'b1;
        b_signed_in = 1'b1;
      end
      F_MULHSU: a_signed_in = 1'b1;
      default: begin
        a_signed_in = 1'b0;
        b_signed_in = 1'b0;
      end
    endcase
    a_neg_in = a_signed_in && op_a[XLEN-1];
    b_neg_in = b_signed_in && op_b[XLEN-1];
    abs_a_in = a_neg_in ? -op_a : op_a;
    abs_b_in = b_neg_in ? -op_b : op_b;
    case (funct3)
      F_MULH, F_DIV:   neg_in = a_neg_in ^ b_neg_in;
      F_MULHSU, F_REM: neg_in = a_neg_in;
      default:         neg_in = 1'b0;
    endcase
    div_zero_in = funct3[2] && (op_b == '0);
    overflow_in = funct3[2] && !funct3[0] && (op_a == MIN_NEG) && (op_b == '1);
    quick_in    = div_zero_in || overflow_in;
    if (div_zero_in) begin
      quick_result = funct3[1] ? op_a : '1;
    end else if (overflow_in) begin
      quick_result = funct3[1] ? '0 : op_a;
    end
`ifdef MULDIV_FAST_MUL_EN
    fast_prod = {{XLEN{a_neg_in}}, op_a} * {{XLEN{b_neg_in}}, op_b};
    if (!funct3[2]) begin
      quick_in     = 1'b1;
      quick_result = (funct3 == F_MUL) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
    end
`endif
  end

  // One radix-2 step for each algorithm plus the sign fix-up and result selection.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(XLEN+1){1'b0}});
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opb_q};
    prod_fix  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
    quot_fix  = neg_q ? -lo_q : lo_q;
    rem_fix   = neg_q ? -hi_q : hi_q;
    case (op_q)
      F_MUL:                     fix_result = prod_fix[XLEN-1:0];
      F_MULH, F_MULHSU, F_MULHU: fix_result = prod_fix[2*XLEN-1:XLEN];
      F_DIV, F_DIVU:             fix_result = quot_fix;
      F_REM, F_REMU:             fix_result = rem_fix;
      default:                   fix_result = '0;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: shortcuts jump straight to DONE, flush aborts back to IDLE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          state_next = quick_in ? DONE : CALC;
        end else begin
          state_next = IDLE;
        end
      end
      CALC: begin
        if (flush) begin
          state_next = IDLE;
        end else if (cnt_q == LAST_ITER) begin
          state_next = FIX;
        end
      end
      FIX: begin
        state_next = flush ? IDLE : DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Operation datapath: latch on accept, iterate in CALC, publish result/tag on the way into DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q    <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opb_q   <= '0;
      cnt_q   <= '0;
      tag_q   <= '0;
      result  <= '0;
      tag_out <= '0;
    end else if (accept) begin
      op_q  <= funct3;
      neg_q <= neg_in;
      hi_q  <= '0;
      lo_q  <= abs_a_in;
      opb_q <= abs_b_in;
      cnt_q <= '0;
      tag_q <= tag_in;
      if (quick_in) begin
        result  <= quick_result;
        tag_out <= tag_in;
      end
    end else if ((state == CALC) && !flush) begin
      cnt_q <= cnt_q + CNT_W'(1);
      if (op_q[2]) begin
        if (!div_diff[XLEN]) begin
          hi_q <= div_diff[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b1};
        end else begin
          hi_q <= div_shift[XLEN-1:0];
          lo_q <= {lo_q[XLEN-2:0], 1'b0};
        end
      end else begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end
    end else if ((state == FIX) && !flush) begin
      result  <= fix_result;
      tag_out <= tag_q;
    end
  end

endmodule

// File: tb/tb_riscvy_muldiv.sv
// tb_riscvy_muldiv: randomized and directed checks of riscvy_muldiv against an arithmetic
// reference model (wide products, language division/remainder, RV special-case rules).
module tb_riscvy_muldiv;

  localparam int XLEN    = 64;
  localparam int TAG_W   = 5;
  localparam int TIMEOUT = XLEN + 20;
`ifdef MULDIV_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] ALL_ONE = {XLEN{1'b1}};

  logic             clk;
  logic             reset;
  logic             start;
  logic [2:0]       funct3;
  logic [XLEN-1:0]  op_a;
  logic [XLEN-1:0]  op_b;
  logic [TAG_W-1:0] tag_in;
  logic             flush;
  logic             busy;
  logic             done;
  logic [XLEN-1:0]  result;
  logic [TAG_W-1:0] tag_out;

  int tests_run;
  int tests_failed;

  typedef struct {
    logic [2:0]      f;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
    int              lat;
  } vec_t;

  riscvy_muldiv #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct3  (funct3),
    .op_a    (op_a),
    .op_b    (op_b),
    .tag_in  (tag_in),
    .flush   (flush),
    .busy    (busy),
    .done    (done),
    .result  (result),
    .tag_out (tag_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference result straight from the RV M-extension definitions.
  function automatic logic [XLEN-1:0] ref_result(input logic [2:0] f, input logic [XLEN-1:0] a,
                                                  input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    logic signed [XLEN-1:0] sa;
    logic signed [XLEN-1:0] sb;
    logic signed [XLEN-1:0] sr;
    sa = a;
    sb = b;
    case (f)
      3'd0: begin p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b}; return p[XLEN-1:0]; end
      3'd1: begin p = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b}; return p[2*XLEN-1:XLEN]; end
      3'd2: begin p = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{1'b0}}, b}; return p[2*XLEN-1:XLEN]; end
      3'd3: begin p = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b}; return p[2*XLEN-1:XLEN]; end
      3'd4: begin
        if (b == '0) return ALL_ONE;
        if (a == MIN_NEG && b == ALL_ONE) return a;
        sr = sa / sb;
        return sr;
      end
      3'd5: return (b == '0) ? ALL_ONE : a / b;
      3'd6: begin
        if (b == '0) return a;
        if (a == MIN_NEG && b == ALL_ONE) return '0;
        sr = sa % sb;
        return sr;
      end
      default: return (b == '0) ? a : a % b;
    endcase
  endfunction

  // Cycles from accept to done: shortcuts take one, everything else XLEN+2.
  function automatic int ref_latency(input logic [2:0] f, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
    if (!f[2]) return FAST_MUL ? 1 : XLEN + 2;
    if (b == '0) return 1;
    if (!f[0] && a == MIN_NEG && b == ALL_ONE) return 1;
    return XLEN + 2;
  endfunction

  // Drive one request in the current cycle (caller sits at a negedge) and wait for its done.
  task automatic apply_stimulus(input logic [2:0] f, input logic [XLEN-1:0] a,
                                input logic [XLEN-1:0] b, input logic [TAG_W-1:0] t,
                                output int lat, output logic [XLEN-1:0] res,
                                output logic [TAG_W-1:0] tg, output bit busy_ok);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    tag_in = t;
    @(negedge clk);
    start   = 1'b0;
    funct3  = 3'($urandom);
    op_a    = {$urandom, $urandom};
    op_b    = {$urandom, $urandom};
    tag_in  = TAG_W'($urandom);
    lat     = 0;
    res     = '0;
    tg      = '0;
    busy_ok = 1'b1;
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (done) begin
        lat = c;
        res = result;
        tg  = tag_out;
        if (busy !== 1'b0) busy_ok = 1'b0;
        break;
      end
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    funct3 = '0;
    op_a = '0;
    op_b = '0;
    tag_in = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy got %b want 0", busy); end
    tests_run++;
    if (done !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_done got %b want 0", done); end
    tests_run++;
    if (result !== '0) begin tests_failed++; $display("[TB] FAIL reset_result got %h want 0", result); end
    tests_run++;
    if (tag_out !== '0) begin tests_failed++; $display("[TB] FAIL reset_tag got %h want 0", tag_out); end
  endtask

  task automatic test_directed();
    vec_t vecs[14];
    int mul_lat;
    int lat;
    logic [XLEN-1:0] res;
    logic [TAG_W-1:0] tg;
    bit busy_ok;
    mul_lat = FAST_MUL ? 1 : XLEN + 2;
    vecs[0]  = '{f:3'd0, a:64'd7, b:64'hFFFF_FFFF_FFFF_FFFD, exp:64'hFFFF_FFFF_FFFF_FFEB, lat:mul_lat};
    vecs[1]  = '{f:3'd3, a:ALL_ONE, b:ALL_ONE, exp:64'hFFFF_FFFF_FFFF_FFFE, lat:mul_lat};
    vecs[2]  = '{f:3'd1, a:ALL_ONE, b:ALL_ONE, exp:64'd0, lat:mul_lat};
    vecs[3]  = '{f:3'd2, a:ALL_ONE, b:64'd2, exp:ALL_ONE, lat:mul_lat};
    vecs[4]  = '{f:3'd4, a:64'hFFFF_FFFF_FFFF_FFF9, b:64'd2, exp:64'hFFFF_FFFF_FFFF_FFFD, lat:XLEN + 2};
    vecs[5]  = '{f:3'd6, a:64'hFFFF_FFFF_FFFF_FFF9, b:64'd2, exp:ALL_ONE, lat:XLEN + 2};
    vecs[6]  = '{f:3'd5, a:64'd100, b:64'd7, exp:64'd14, lat:XLEN + 2};
    vecs[7]  = '{f:3'd7, a:64'd100, b:64'd7, exp:64'd2, lat:XLEN + 2};
    vecs[8]  = '{f:3'd4, a:64'd12345, b:64'd0, exp:ALL_ONE, lat:1};
    vecs[9]  = '{f:3'd6, a:64'd9, b:64'd0, exp:64'd9, lat:1};
    vecs[10] = '{f:3'd4, a:MIN_NEG, b:ALL_ONE, exp:MIN_NEG, lat:1};
    vecs[11] = '{f:3'd6, a:MIN_NEG, b:ALL_ONE, exp:64'd0, lat:1};
    vecs[12] = '{f:3'd5, a:64'd5, b:64'd0, exp:ALL_ONE, lat:1};
    vecs[13] = '{f:3'd7, a:64'hDEAD, b:64'd0, exp:64'hDEAD, lat:1};
    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i].f, vecs[i].a, vecs[i].b, TAG_W'(i + 5), lat, res, tg, busy_ok);
      tests_run++;
      if (lat !== vecs[i].lat) begin
        tests_failed++; $display("[TB] FAIL directed_latency[%0d] got %0d want %0d", i, lat, vecs[i].lat);
      end
      tests_run++;
      if (res !== vecs[i].exp) begin
        tests_failed++; $display("[TB] FAIL directed_result[%0d] got %h want %h", i, res, vecs[i].exp);
      end
      tests_run++;
      if (tg !== TAG_W'(i + 5)) begin
        tests_failed++; $display("[TB] FAIL directed_tag[%0d] got %0d want %0d", i, tg, i + 5);
      end
      tests_run++;
      if (busy_ok !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL directed_busy[%0d] got bad busy profile want high until done", i);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0] f;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [TAG_W-1:0] t;
    int lat;
    logic [XLEN-1:0] res;
    logic [TAG_W-1:0] tg;
    bit busy_ok;
    for (int i = 0; i < 40; i++) begin
      f = 3'($urandom);
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      t = TAG_W'($urandom);
      case ($urandom_range(0, 5))
        0: begin a = XLEN'($urandom_range(0, 20)); b = XLEN'($urandom_range(1, 9)); end
        1: begin a = -XLEN'($urandom_range(0, 20)); b = -XLEN'($urandom_range(1, 9)); end
        2: b = '0;
        3: begin a = MIN_NEG; b = ALL_ONE; end
        4: b = XLEN'($urandom);
        default: ;
      endcase
      apply_stimulus(f, a, b, t, lat, res, tg, busy_ok);
      tests_run++;
      if (res !== ref_result(f, a, b)) begin
        tests_failed++;
        $display("[TB] FAIL random_result f=%0d a=%h b=%h got %h want %h", f, a, b, res, ref_result(f, a, b));
      end
      tests_run++;
      if (lat !== ref_latency(f, a, b)) begin
        tests_failed++; $display("[TB] FAIL random_latency f=%0d got %0d want %0d", f, lat, ref_latency(f, a, b));
      end
      tests_run++;
      if (tg !== t || busy_ok !== 1'b1) begin
        tests_failed++; $display("[TB] FAIL random_tag_busy got tag %0d busy_ok %0d want tag %0d busy_ok 1", tg, busy_ok, t);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] f;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    int lat;
    logic [XLEN-1:0] res;
    logic [TAG_W-1:0] tg;
    bit busy_ok;
    for (int i = 0; i < 8; i++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      if (FAST_MUL && ($urandom_range(0, 1) == 1)) begin
        f = 3'($urandom_range(0, 3));
      end else begin
        f = 3'($urandom_range(4, 7));
        b = '0;
      end
      apply_stimulus(f, a, b, TAG_W'(i), lat, res, tg, busy_ok);
      tests_run++;
      if (lat !== 1 || res !== ref_result(f, a, b) || tg !== TAG_W'(i)) begin
        tests_failed++;
        $display("[TB] FAIL back_to_back[%0d] got lat %0d res %h tag %0d want lat 1 res %h tag %0d",
                 i, lat, res, tg, ref_result(f, a, b), i);
      end
    end
  endtask

  task automatic test_ignore_while_busy();
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    int lat;
    int extra;
    logic [XLEN-1:0] res;
    logic [TAG_W-1:0] tg;
    a = {$urandom, $urandom};
    b = XLEN'($urandom_range(3, 1000));
    start = 1'b1; funct3 = 3'd5; op_a = a; op_b = b; tag_in = 5'd17;
    @(negedge clk);
    start = 1'b0;
    lat = 0; res = '0; tg = '0;
    for (int c = 1; c <= TIMEOUT; c++) begin
      if (done) begin lat = c; res = result; tg = tag_out; break; end
      if (c == 5) begin
        start = 1'b1; funct3 = 3'd0; op_a = 64'd6; op_b = 64'd7; tag_in = 5'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    tests_run++;
    if (lat !== XLEN + 2 || res !== a / b || tg !== 5'd17) begin
      tests_failed++;
      $display("[TB] FAIL ignore_busy_first got lat %0d res %h tag %0d want lat %0d res %h tag 17",
               lat, res, tg, XLEN + 2, a / b);
    end
    extra = 0;
    repeat (XLEN + 4) begin
      @(negedge clk);
      if (done) extra++;
    end
    tests_run++;
    if (extra !== 0) begin tests_failed++; $display("[TB] FAIL ignore_busy_queued got %0d dones want 0", extra); end
  endtask

  task automatic test_flush();
    int lat;
    int seen;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [TAG_W-1:0] tg;
    bit busy_ok;
    apply_stimulus(3'd7, 64'd100, 64'd7, 5'd9, lat, res, tg, busy_ok);
    tests_run++;
    if (res !== 64'd2) begin tests_failed++; $display("[TB] FAIL flush_prior got %h want 2", res); end
    start = 1'b1; funct3 = 3'd5; op_a = {$urandom, $urandom}; op_b = XLEN'($urandom_range(1, 99)); tag_in = 5'd21;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 1; c < 10; c++) begin
      if (done) seen++;
      @(negedge clk);
    end
    if (done) seen++;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0 || seen !== 0) begin
      tests_failed++; $display("[TB] FAIL flush_idle got busy %b done %b early %0d want 0 0 0", busy, done, seen);
    end
    tests_run++;
    if (result !== 64'd2 || tag_out !== 5'd9) begin
      tests_failed++; $display("[TB] FAIL flush_hold got %h/%0d want 2/9", result, tag_out);
    end
    a = {$urandom, $urandom};
    b = -XLEN'($urandom_range(2, 50));
    apply_stimulus(3'd4, a, b, 5'd30, lat, res, tg, busy_ok);
    tests_run++;
    if (lat !== XLEN + 2 || res !== ref_result(3'd4, a, b) || tg !== 5'd30 || busy_ok !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL flush_restart got lat %0d res %h tag %0d want lat %0d res %h tag 30",
               lat, res, tg, XLEN + 2, ref_result(3'd4, a, b));
    end
  endtask

  task automatic test_flush_with_start();
    logic [XLEN-1:0] prior;
    int seen;
    @(negedge clk);
    prior = result;
    start = 1'b1; flush = 1'b1; funct3 = 3'd5; op_a = 64'd1000; op_b = 64'd3; tag_in = 5'd1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    seen = 0;
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_start_busy got %b want 0", busy); end
    repeat (XLEN + 4) begin
      if (done) seen++;
      @(negedge clk);
    end
    tests_run++;
    if (seen !== 0 || result !== prior) begin
      tests_failed++; $display("[TB] FAIL flush_start_drop got %0d dones result %h want 0 dones result %h", seen, result, prior);
    end
  endtask

  task automatic test_reset_mid();
    int seen;
    start = 1'b1; funct3 = 3'd4; op_a = {$urandom, $urandom}; op_b = 64'd13; tag_in = 5'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      tests_failed++; $display("[TB] FAIL reset_mid_ctrl got busy %b done %b want 0 0", busy, done);
    end
    tests_run++;
    if (result !== '0 || tag_out !== '0) begin
      tests_failed++; $display("[TB] FAIL reset_mid_data got %h/%0d want 0/0", result, tag_out);
    end
    seen = 0;
    repeat (XLEN + 4) begin
      @(negedge clk);
      if (done) seen++;
    end
    tests_run++;
    if (seen !== 0) begin tests_failed++; $display("[TB] FAIL reset_mid_done got %0d dones want 0", seen); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_ignore_while_busy();
    test_flush();
    test_flush_with_start();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
